pulse: RTL and testbench
========================

# pulse

Six-axis stepper pulse generator for the motor-control datapath, clocked from `sysclk`. After reset it homes each axis in turn by stepping toward the origin until that axis's Stop (limit) input asserts. It then executes move commands, emitting an exact number of step pulses on the selected axes. It reports progress through `Busy`, the per-axis `initFlag`, and the start/done strobes `SS`/`DSS`.

## Interface
- `N_MOTOR`, default 6: number of axes.
- `CNT_W`, default 10: width of `PulseNum`.
- `PERIOD`, default 100: `sysclk` cycles per step pulse (1000 ns at 10 ns clock).
- `HIGH`, default 50: cycles `PU` is high within each period.
- `sysclk` in 1: the only clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `Motor` in 6: axis select mask for moves; multiple bits allowed.
- `PulseNum` in 10: step count for a move, unsigned.
- `Stop` in 6: per-axis origin/limit switch, active-high, level.
- `Busy` out 1: high while homing or moving.
- `initFlag` out 6: bit i set once axis i is homed.
- `SS` out 1: one-cycle strobe when a move is accepted.
- `DSS` out 1: one-cycle strobe when a move completes, and when the last axis finishes homing.
- `PU` out 6: step pulse per axis.
- `MF` out 6: direction per axis; 1 = away from origin (move), 0 = toward origin (homing).

## Operation
- States: `HOME` (with axis index k = 0..5), `IDLE`, `MOVE`.
- Reset values: all outputs 0, state `HOME`, k = 0, phase counter 0, last-command register = 0.
  - `Busy` becomes 1 on the first cycle after `rst` deasserts.
- Reset mid-operation aborts immediately and homing restarts from axis 0.
- `HOME`:
  - `PU[k]` toggles at the step rate; `MF[k]` = 0.
  - When `Stop[k]` is sampled high, `PU[k]` is forced low that cycle, `initFlag[k]` is set and the phase counter is cleared.
  - k then increments. After k = 5, the block asserts `DSS` for one cycle and enters `IDLE`.
  - `Stop` bits of axes other than k are ignored.
- `IDLE`:
  - `Busy` = 0.
  - A command is accepted when `Motor != 0`, `PulseNum != 0`, and {`Motor`,`PulseNum`} differs from the last accepted command.
  - On acceptance: capture mask and count, update the last-command register, pulse `SS`, set `MF` = captured mask, and enter `MOVE`.
  - Changing only `PulseNum` with the same `Motor` is a new command.
  - A change made while not in `IDLE` is acted on at the first `IDLE` cycle; only the latest input values count.
- `MOVE`:
  - Every axis in the captured mask emits exactly N pulses in phase; all other `PU` bits stay 0.
  - A down-counter decrements at the end of each period. When it reaches 0, the block pulses `DSS` and returns to `IDLE`.
  - `Stop` is ignored in `MOVE`.
- `MF` holds its last value in `IDLE`.

## Timing
- Phase counter runs 0..PERIOD-1.
  - `PU` is high for phase 0..HIGH-1 and low for phase HIGH..PERIOD-1.
  - So `PU` is 50 cycles high, 50 cycles low.
- Move latency:
  - `SS` is asserted in the cycle after the accepting input is sampled.
  - `Busy` and the first `PU` rise are registered in the same cycle as `SS`.
- Move duration: N*PERIOD cycles of `Busy` high. `DSS` is asserted in the cycle `Busy` falls.
- The last pulse's low half is always completed before `DSS`.
- Homing Stop response:
  - `PU[k]` is low and `initFlag[k]` set one cycle after `Stop[k]` is sampled.
  - The next axis starts pulsing the following cycle at phase 0.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `pulse_pkg`: `N_MOTOR`, `PERIOD`, `HIGH`, and the state enum {`HOME`, `IDLE`, `MOVE`}.
- One sub-module, `pulse_phase`: free-running PERIOD counter with a clear input. It outputs the high-phase flag and an end-of-period tick.
- Top level holds the FSM, axis index, step down-counter, last-command register and output registers.

## Test plan
- Reset then homing:
  - Stimulus: hold `rst` 3 cycles; pulse `Stop` = 000001 after 10 µs for 2 µs, then 000010, …, 100000 in sequence.
  - Response: `PU[0]` toggles with 1000 ns period until its Stop; `initFlag` walks 000001 → 111111.
  - `DSS` pulses once after axis 5; then `Busy` = 0 and `MF` = 0.
- Move: `Motor` = 000010, `PulseNum` = 5.
  - Response: `SS` once; exactly 5 pulses on `PU[1]` and none on others; `MF` = 000010; `Busy` high 500 cycles; `DSS` once.
- Re-command same axis: `PulseNum` changes to 2 → 2 pulses on `PU[1]`.
  - Holding the inputs steady afterwards produces no further pulses.
- Axis switch: `Motor` = 001000, `PulseNum` = 5 → 5 pulses on `PU[3]`.
  - Inputs changed while `Busy` execute only after the current move's `DSS`.
- Edge cases:
  - `PulseNum` = 0 or `Motor` = 0 → no `SS`.
  - `Motor` = 000011, `PulseNum` = 3 → `PU[0]` and `PU[1]` give 3 identical pulses.
  - `Stop` pulsed during `MOVE` → ignored.
  - `rst` during `MOVE` → all outputs 0, homing restarts at axis 0.

Source files
------------

// File: rtl/pulse_pkg.sv
// Shared constants and state encoding for the six-axis step pulse generator.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package pulse_pkg;

  localparam int N_MOTOR = 6;
  localparam int PERIOD  = 100;
  localparam int HIGH    = 50;

  typedef enum logic [1:0] {
    HOME,
    IDLE,
    MOVE
  } state_t;

endpackage

// File: rtl/pulse_phase.sv
// Free-running step-period phase counter with synchronous clear.
// Latency: hi/tick are decoded directly from the registered phase.
// Backpressure: none; clear restarts the period at phase 0 on the next edge.
module pulse_phase #(
  parameter int PERIOD = pulse_pkg::PERIOD,
  parameter int HIGH   = pulse_pkg::HIGH
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic hi,
  output logic tick
);
  import pulse_pkg::*;

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PW-1:0] phase;

  // Count 0..PERIOD-1 and wrap; clear forces the next period to start at 0.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      phase <= '0;
    end else if (phase == PW'(PERIOD - 1)) begin
      phase <= '0;
    end else begin
      phase <= phase + PW'(1);
    end
  end

  assign hi   = (phase < PW'(HIGH));
  assign tick = (phase == PW'(PERIOD - 1));

endmodule

// File: rtl/pulse.sv
// Six-axis stepper pulse generator: homes every axis, then runs exact-count moves.
// Latency: all outputs registered; SS and first PU rise one cycle after the accepting input.
// Backpressure: commands are only sampled in IDLE; changes made while busy wait for IDLE.
module pulse #(
  parameter int N_MOTOR = pulse_pkg::N_MOTOR,
  parameter int CNT_W   = 10,
  parameter int PERIOD  = pulse_pkg::PERIOD,
  parameter int HIGH    = pulse_pkg::HIGH
) (
  input  logic               sysclk,
  input  logic               rst,
  input  logic [N_MOTOR-1:0] Motor,
  input  logic [CNT_W-1:0]   PulseNum,
  input  logic [N_MOTOR-1:0] Stop,
  output logic               Busy,
  output logic [N_MOTOR-1:0] initFlag,
  output logic               SS,
  output logic               DSS,
  output logic [N_MOTOR-1:0] PU,
  output logic [N_MOTOR-1:0] MF
);
  import pulse_pkg::*;

  localparam int KW = (N_MOTOR > 1) ? $clog2(N_MOTOR) : 1;

  state_t                     state;
  logic [KW-1:0]              k;
  logic [CNT_W-1:0]           steps;
  logic [N_MOTOR+CNT_W-1:0]   last_cmd;

  logic                       ph_hi;
  logic                       ph_tick;
  logic                       ph_clr;
  logic [N_MOTOR+CNT_W-1:0]   cmd;
  logic                       accept;
  logic                       stop_hit;
  logic                       move_done;
  logic [N_MOTOR-1:0]         home_axis;

  assign cmd       = {Motor, PulseNum};
  assign accept    = (state == IDLE) && (|Motor) && (|PulseNum) && (cmd != last_cmd);
  assign stop_hit  = (state == HOME) && Stop[k];
  assign move_done = (state == MOVE) && (steps == '0);
  assign home_axis = {{(N_MOTOR-1){1'b0}}, 1'b1} << k;

  // Phase restarts at 0 whenever a new axis or a new move is about to start,
  // so the first pulse is always a full-width high half.
  assign ph_clr = ((state == IDLE) && !accept) || stop_hit || move_done;

  pulse_phase #(
    .PERIOD (PERIOD),
    .HIGH   (HIGH)
  ) u_phase (
    .clk  (sysclk),
    .rst  (rst),
    .clr  (ph_clr),
    .hi   (ph_hi),
    .tick (ph_tick)
  );

  // Control FSM with registered outputs; MF doubles as the captured move mask.
  always_ff @(posedge sysclk) begin
    if (rst) begin
      state    <= HOME;
      k        <= '0;
      steps    <= '0;
      last_cmd <= '0;
      Busy     <= 1'b0;
      initFlag <= '0;
      SS       <= 1'b0;
      DSS      <= 1'b0;
      PU       <= '0;
      MF       <= '0;
    end else begin
      SS  <= 1'b0;
      DSS <= 1'b0;
      unique case (state)
        HOME: begin
          MF <= '0;
          if (Stop[k]) begin
            PU          <= '0;
            initFlag[k] <= 1'b1;
            if (k == KW'(N_MOTOR - 1)) begin
              k     <= '0;
              Busy  <= 1'b0;
              DSS   <= 1'b1;
              state <= IDLE;
            end else begin
              k    <= k + KW'(1);
              Busy <= 1'b1;
            end
          end else begin
            PU   <= ph_hi ? home_axis : '0;
            Busy <= 1'b1;
          end
        end
        IDLE: begin
          Busy <= 1'b0;
          PU   <= '0;
          if (accept) begin
            SS       <= 1'b1;
            Busy     <= 1'b1;
            MF       <= Motor;
            PU       <= Motor;
            steps    <= PulseNum;
            last_cmd <= cmd;
            state    <= MOVE;
          end
        end
        MOVE: begin
          if (steps == '0) begin
            // Final period's low half has just completed.
            Busy  <= 1'b0;
            DSS   <= 1'b1;
            PU    <= '0;
            state <= IDLE;
          end else begin
            PU <= ph_hi ? MF : '0;
            if (ph_tick) begin
              steps <= steps - CNT_W'(1);
            end
          end
        end
        default: begin
          state <= HOME;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pulse.sv
// Self-checking bench for pulse: homing walk, command table, corner sequences, random moves.
module tb_pulse;

  localparam int PERIOD = 100;
  localparam int HIGH   = 50;

  logic       sysclk = 1'b0;
  logic       rst;
  logic [5:0] Motor;
  logic [9:0] PulseNum;
  logic [5:0] Stop;
  logic       Busy;
  logic [5:0] initFlag;
  logic       SS;
  logic       DSS;
  logic [5:0] PU;
  logic [5:0] MF;

  int checks = 0;
  int errors = 0;

  pulse dut (
    .sysclk   (sysclk),
    .rst      (rst),
    .Motor    (Motor),
    .PulseNum (PulseNum),
    .Stop     (Stop),
    .Busy     (Busy),
    .initFlag (initFlag),
    .SS       (SS),
    .DSS      (DSS),
    .PU       (PU),
    .MF       (MF)
  );

  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [5:0] m;
    logic [9:0] n;
    bit         exp_ss;
    int         exp_pulses;
  } vec_t;

  // Reference: last accepted command, tracked from the acceptance rule alone.
  logic [5:0] last_m;
  logic [9:0] last_n;

  task automatic step();
    @(negedge sysclk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic bit model_accepts(input logic [5:0] m, input logic [9:0] n);
    return (m != 6'd0) && (n != 10'd0) && ({m, n} != {last_m, last_n});
  endfunction

  // Inputs for the move are already applied; the next edge should accept it.
  task automatic expect_move(input logic [5:0] mask, input int n, input string tag,
                             input bit chg, input logic [5:0] m2, input logic [9:0] n2,
                             input bit rstop);
    int rises[6];
    logic [5:0] prev;
    int busy_cnt;
    int bad;
    bit done;
    for (int a = 0; a < 6; a++) rises[a] = 0;
    prev = 6'd0;
    busy_cnt = 0;
    bad = 0;
    done = 1'b0;
    step();
    chk({tag, "_ss"}, int'(SS), 1);
    chk({tag, "_mf"}, int'(MF), int'(mask));
    for (int c = 0; c < n * PERIOD + 50 && !done; c++) begin
      if (c > 0) step();
      if (Busy) begin
        busy_cnt++;
        for (int a = 0; a < 6; a++)
          if (PU[a] && !prev[a]) rises[a]++;
        if (PU != 6'd0 && PU != mask) bad++;
        if (MF != mask) bad++;
        if (DSS) bad++;
        if (c > 0 && SS) bad++;
        prev = PU;
        if (chg && c == 30) begin
          Motor    = m2;
          PulseNum = n2;
        end
        if (rstop) Stop = 6'($urandom);
      end else begin
        done = 1'b1;
      end
    end
    Stop = 6'd0;
    chk({tag, "_finished"}, int'(done), 1);
    chk({tag, "_busy_cycles"}, busy_cnt, n * PERIOD);
    chk({tag, "_dss"}, int'(DSS), 1);
    chk({tag, "_pu_idle"}, int'(PU), 0);
    chk({tag, "_shape"}, bad, 0);
    for (int a = 0; a < 6; a++)
      chk($sformatf("%s_pulses_axis%0d", tag, a), rises[a], mask[a] ? n : 0);
  endtask

  task automatic expect_idle(input string tag);
    int bad;
    bad = 0;
    for (int c = 0; c < 4; c++) begin
      step();
      if (SS || DSS || Busy || PU != 6'd0) bad++;
    end
    chk({tag, "_no_move"}, bad, 0);
  endtask

  vec_t       tbl[7];
  int         w;
  int         bad;
  logic [5:0] rm;
  logic [9:0] rn;

  initial begin
    tbl[0] = '{6'b000010, 10'd5, 1'b1, 5};
    tbl[1] = '{6'b000010, 10'd2, 1'b1, 2};
    tbl[2] = '{6'b000010, 10'd2, 1'b0, 0};
    tbl[3] = '{6'b001000, 10'd5, 1'b1, 5};
    tbl[4] = '{6'b000000, 10'd7, 1'b0, 0};
    tbl[5] = '{6'b000101, 10'd0, 1'b0, 0};
    tbl[6] = '{6'b000011, 10'd3, 1'b1, 3};

    last_m   = 6'd0;
    last_n   = 10'd0;
    Stop     = 6'd0;
    Motor    = 6'd0;
    PulseNum = 10'd0;
    rst      = 1'b1;
    repeat (3) step();
    chk("reset_outputs", int'({Busy, initFlag, SS, DSS, PU, MF}), 0);
    rst = 1'b0;

    // Homing: each axis steps toward origin until its Stop is seen.
    for (int k = 0; k < 6; k++) begin
      w = 150 + 37 * k;
      bad = 0;
      for (int j = 0; j < w; j++) begin
        step();
        if (PU !== (((j % PERIOD) < HIGH) ? 6'(1 << k) : 6'd0)) bad++;
        if (MF !== 6'd0 || Busy !== 1'b1 || initFlag !== 6'((1 << k) - 1) || SS || DSS) bad++;
      end
      chk($sformatf("home_wave_axis%0d", k), bad, 0);
      Stop = 6'(1 << k);
      step();
      chk($sformatf("home_pu_low_axis%0d", k), int'(PU), 0);
      chk($sformatf("home_initflag_axis%0d", k), int'(initFlag), (2 << k) - 1);
      chk($sformatf("home_dss_axis%0d", k), int'(DSS), (k == 5) ? 1 : 0);
      chk($sformatf("home_busy_axis%0d", k), int'(Busy), (k == 5) ? 0 : 1);
    end
    Stop = 6'd0;
    step();
    chk("home_dss_single", int'(DSS), 0);
    chk("home_idle_busy", int'(Busy), 0);
    chk("home_idle_mf", int'(MF), 0);
    chk("home_idle_initflag", int'(initFlag), 63);

    // Command table.
    for (int i = 0; i < 7; i++) begin
      Motor    = tbl[i].m;
      PulseNum = tbl[i].n;
      if (tbl[i].exp_ss) begin
        expect_move(tbl[i].m, tbl[i].exp_pulses, $sformatf("tbl%0d", i), 1'b0, 6'd0, 10'd0, 1'b1);
        last_m = tbl[i].m;
        last_n = tbl[i].n;
      end else begin
        expect_idle($sformatf("tbl%0d", i));
      end
    end

    // Inputs changed mid-move run only after the current move's DSS.
    Motor    = 6'b100000;
    PulseNum = 10'd2;
    expect_move(6'b100000, 2, "mid_a", 1'b1, 6'b010001, 10'd1, 1'b0);
    expect_move(6'b010001, 1, "mid_b", 1'b0, 6'd0, 10'd0, 1'b0);
    last_m = 6'b010001;
    last_n = 10'd1;

    // Reset during a move aborts and restarts homing at axis 0.
    Motor    = 6'b000100;
    PulseNum = 10'd3;
    step();
    chk("rstmove_ss", int'(SS), 1);
    repeat (120) step();
    chk("rstmove_busy_before", int'(Busy), 1);
    rst = 1'b1;
    step();
    chk("rstmove_outputs", int'({Busy, initFlag, SS, DSS, PU, MF}), 0);
    rst = 1'b0;
    step();
    chk("rstmove_rehome_busy", int'(Busy), 1);
    chk("rstmove_rehome_pu", int'(PU), 1);
    Stop = 6'b111111;
    repeat (6) step();
    chk("rstmove_rehome_initflag", int'(initFlag), 63);
    chk("rstmove_rehome_dss", int'(DSS), 1);
    chk("rstmove_rehome_busy_low", int'(Busy), 0);
    Stop = 6'd0;
    // Last-command memory was cleared, so the held command runs again.
    expect_move(6'b000100, 3, "rstmove_again", 1'b0, 6'd0, 10'd0, 1'b0);
    last_m = 6'b000100;
    last_n = 10'd3;

    // Random commands against the acceptance model.
    for (int i = 0; i < 16; i++) begin
      rm = (($urandom % 4) == 0) ? 6'd0 : 6'($urandom);
      rn = 10'($urandom_range(0, 4));
      if (($urandom % 5) == 0) begin
        rm = last_m;
        rn = last_n;
      end
      Motor    = rm;
      PulseNum = rn;
      if (model_accepts(rm, rn)) begin
        expect_move(rm, int'(rn), $sformatf("rnd%0d", i), 1'b0, 6'd0, 10'd0, 1'b1);
        last_m = rm;
        last_n = rn;
      end else begin
        expect_idle($sformatf("rnd%0d", i));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
